// File: rtl/pipeline_mem_pkg.sv
// Shared definitions for the MEM pipeline stage: memory opcodes, access size
// encoding, FSM states and small mask helpers.
package pipeline_pkg;

  localparam logic [31:0] OP_NONE  = 32'd0;
  localparam logic [31:0] OP_LOAD  = 32'd1;
  localparam logic [31:0] OP_STORE = 32'd2;

  // Access size: [1:0] = log2(bytes), [2] = zero-extend the loaded value.
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;
  localparam int         SIZE_ZEXT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE:  align_mask = 3'b000;
      SIZE_HALF:  align_mask = 3'b001;
      SIZE_WORD:  align_mask = 3'b011;
      SIZE_DWORD: align_mask = 3'b111;
      default:    align_mask = 3'b111;
    endcase
  endfunction

  // Byte-enable pattern for an access of the given size at lane 0.
  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE:  lane_mask = 8'h01;
      SIZE_HALF:  lane_mask = 8'h03;
      SIZE_WORD:  lane_mask = 8'h0F;
      SIZE_DWORD: lane_mask = 8'hFF;
      default:    lane_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_mem_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface pipeline_mem_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [7:0]            req_strb;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_strb,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_strb,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/pipeline_mem_load_align.sv
// Picks the addressed bytes out of an aligned doubleword and sign- or
// zero-extends them to the full datapath width.
module mem_load_align
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] resp_data,
  input  logic [2:0]            byte_off,
  input  logic [2:0]            size,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [DATA_WIDTH-1:0] shifted_s;
  logic                  zext_s;

  // Shift the addressed lane down to bit 0, then extend by access size.
  always_comb begin
    shifted_s = resp_data >> {byte_off, 3'b000};
    zext_s    = size[SIZE_ZEXT_BIT];
    load_data = shifted_s;
    case (size[1:0])
      SIZE_BYTE: load_data = {{(DATA_WIDTH-8){~zext_s & shifted_s[7]}}, shifted_s[7:0]};
      SIZE_HALF: load_data = {{(DATA_WIDTH-16){~zext_s & shifted_s[15]}}, shifted_s[15:0]};
      SIZE_WORD: load_data = {{(DATA_WIDTH-32){~zext_s & shifted_s[31]}}, shifted_s[31:0]};
      SIZE_DWORD: load_data = shifted_s;
      default:   load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/pipeline_mem.sv
// MEM pipeline stage: accepts one instruction at a time from EX, issues an
// aligned doubleword request for loads/stores, and presents the result to WB.
module pipeline_mem
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] ex_res,
  input  logic [DATA_WIDTH-1:0] r2_val_mem,
  input  logic [4:0]            mem_dst_reg,
  input  logic [31:0]           next_mem_opcode,
  input  logic [2:0]            next_mem_operation_size,
  input  logic                  ecall_mem,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic                  dmem_req_we,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  output logic [7:0]            dmem_req_strb,
  input  logic                  dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_resp_data,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_res,
  output logic [4:0]            wb_dst_reg,
  output logic                  wb_ecall,
  output logic                  wb_misaligned
);

  state_t                state_r, next_state_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  is_load_s, is_store_s, mem_op_s, misaligned_s;
  logic [DATA_WIDTH-1:0] load_data_s;

  logic [4:0]            dst_r;
  logic [2:0]            off_r;
  logic [2:0]            size_r;
  logic                  store_r;
  logic [ADDR_WIDTH-1:0] req_addr_r;
  logic                  req_we_r;
  logic [DATA_WIDTH-1:0] req_wdata_r;
  logic [7:0]            req_strb_r;
  logic [DATA_WIDTH-1:0] wb_res_r;
  logic [4:0]            wb_dst_r;
  logic                  wb_ecall_r;
  logic                  wb_mis_r;

  assign addr_s       = ex_res[ADDR_WIDTH-1:0];
  assign is_load_s    = (next_mem_opcode == OP_LOAD);
  assign is_store_s   = (next_mem_opcode == OP_STORE);
  assign mem_op_s     = (next_mem_opcode != OP_NONE) && (is_load_s || is_store_s);
  assign misaligned_s = |(addr_s[2:0] & align_mask(next_mem_operation_size[1:0]));

  assign dmem_req_addr  = req_addr_r;
  assign dmem_req_we    = req_we_r;
  assign dmem_req_wdata = req_wdata_r;
  assign dmem_req_strb  = req_strb_r;
  assign wb_res         = wb_res_r;
  assign wb_dst_reg     = wb_dst_r;
  assign wb_ecall       = wb_ecall_r;
  assign wb_misaligned  = wb_mis_r;

  mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .resp_data (dmem_resp_data),
    .byte_off  (off_r),
    .size      (size_r),
    .load_data (load_data_s)
  );

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic; OUT always returns to IDLE so there is no back-to-back accept.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) next_state_s = (mem_op_s && !misaligned_s) ? ST_REQ : ST_OUT;
        else          next_state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (dmem_req_ready) next_state_s = store_r ? ST_OUT : ST_WAIT;
        else                next_state_s = ST_REQ;
      end
      ST_WAIT: begin
        if (dmem_resp_valid) next_state_s = ST_OUT;
        else                 next_state_s = ST_WAIT;
      end
      ST_OUT: begin
        if (wb_ready) next_state_s = ST_IDLE;
        else          next_state_s = ST_OUT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    ready          = 1'b0;
    dmem_req_valid = 1'b0;
    wb_valid       = 1'b0;
    case (state_r)
      ST_IDLE: ready          = 1'b1;
      ST_REQ:  dmem_req_valid = 1'b1;
      ST_WAIT: ready          = 1'b0;
      ST_OUT:  wb_valid       = 1'b1;
      default: ready          = 1'b0;
    endcase
  end

  // Capture the instruction on accept and build request / writeback fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_r       <= 5'd0;
      off_r       <= 3'd0;
      size_r      <= 3'd0;
      store_r     <= 1'b0;
      req_addr_r  <= {ADDR_WIDTH{1'b0}};
      req_we_r    <= 1'b0;
      req_wdata_r <= {DATA_WIDTH{1'b0}};
      req_strb_r  <= 8'h00;
      wb_res_r    <= {DATA_WIDTH{1'b0}};
      wb_dst_r    <= 5'd0;
      wb_ecall_r  <= 1'b0;
      wb_mis_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            dst_r      <= mem_dst_reg;
            off_r      <= addr_s[2:0];
            size_r     <= next_mem_operation_size;
            store_r    <= is_store_s;
            wb_ecall_r <= ecall_mem;
            if (!mem_op_s) begin
              wb_res_r <= ex_res;
              wb_dst_r <= mem_dst_reg;
              wb_mis_r <= 1'b0;
            end else if (misaligned_s) begin
              wb_res_r <= ex_res;
              wb_dst_r <= 5'd0;
              wb_mis_r <= 1'b1;
            end else begin
              req_addr_r  <= {addr_s[ADDR_WIDTH-1:3], 3'b000};
              req_we_r    <= is_store_s;
              req_wdata_r <= is_store_s ? (r2_val_mem << {addr_s[2:0], 3'b000})
                                        : {DATA_WIDTH{1'b0}};
              req_strb_r  <= is_store_s ? (lane_mask(next_mem_operation_size[1:0]) << addr_s[2:0])
                                        : 8'h00;
              wb_mis_r    <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (dmem_req_ready && store_r) begin
            wb_res_r <= {DATA_WIDTH{1'b0}};
            wb_dst_r <= 5'd0;
          end
        end
        ST_WAIT: begin
          if (dmem_resp_valid) begin
            wb_res_r <= load_data_s;
            wb_dst_r <= dst_r;
          end
        end
        ST_OUT:  wb_mis_r <= wb_mis_r;
        default: wb_mis_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem.sv
// Directed self-checking bench for the MEM pipeline stage.
module tb_pipeline_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        ready;
  logic [63:0] ex_res;
  logic [63:0] r2_val_mem;
  logic [4:0]  mem_dst_reg;
  logic [31:0] next_mem_opcode;
  logic [2:0]  next_mem_operation_size;
  logic        ecall_mem;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_res;
  logic [4:0]  wb_dst_reg;
  logic        wb_ecall;
  logic        wb_misaligned;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_mem_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) mem ();

  pipeline_mem #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .in_valid                (in_valid),
    .ready                   (ready),
    .ex_res                  (ex_res),
    .r2_val_mem              (r2_val_mem),
    .mem_dst_reg             (mem_dst_reg),
    .next_mem_opcode         (next_mem_opcode),
    .next_mem_operation_size (next_mem_operation_size),
    .ecall_mem               (ecall_mem),
    .dmem_req_valid          (mem.req_valid),
    .dmem_req_ready          (mem.req_ready),
    .dmem_req_addr           (mem.req_addr),
    .dmem_req_we             (mem.req_we),
    .dmem_req_wdata          (mem.req_wdata),
    .dmem_req_strb           (mem.req_strb),
    .dmem_resp_valid         (mem.resp_valid),
    .dmem_resp_data          (mem.resp_data),
    .wb_valid                (wb_valid),
    .wb_ready                (wb_ready),
    .wb_res                  (wb_res),
    .wb_dst_reg              (wb_dst_reg),
    .wb_ecall                (wb_ecall),
    .wb_misaligned           (wb_misaligned)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] op, input logic [63:0] res, input logic [63:0] sd,
                       input logic [2:0] sz, input logic [4:0] dst, input logic ec);
    in_valid                = 1'b1;
    next_mem_opcode         = op;
    ex_res                  = res;
    r2_val_mem              = sd;
    next_mem_operation_size = sz;
    mem_dst_reg             = dst;
    ecall_mem               = ec;
    tick();
    in_valid                = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ex_res = 64'd0; r2_val_mem = 64'd0;
    mem_dst_reg = 5'd0; next_mem_opcode = 32'd0; next_mem_operation_size = 3'd0;
    ecall_mem = 1'b0; wb_ready = 1'b1;
    mem.req_ready = 1'b1; mem.resp_valid = 1'b0; mem.resp_data = 64'd0;
    @(negedge clk); @(negedge clk);

    // Reset state
    chk("rst_ready",   {63'd0, ready}, 64'd1);
    chk("rst_reqv",    {63'd0, mem.req_valid}, 64'd0);
    chk("rst_we",      {63'd0, mem.req_we}, 64'd0);
    chk("rst_wbv",     {63'd0, wb_valid}, 64'd0);
    chk("rst_ecall",   {63'd0, wb_ecall}, 64'd0);
    chk("rst_mis",     {63'd0, wb_misaligned}, 64'd0);
    chk("rst_wbres",   wb_res, 64'd0);
    chk("rst_dst",     {59'd0, wb_dst_reg}, 64'd0);
    chk("rst_addr",    mem.req_addr, 64'd0);
    chk("rst_wdata",   mem.req_wdata, 64'd0);
    chk("rst_strb",    {56'd0, mem.req_strb}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // ALU pass-through, one cycle latency
    wb_ready = 1'b0;
    chk("alu_ready_idle", {63'd0, ready}, 64'd1);
    issue(32'd0, 64'h1234, 64'd0, 3'd3, 5'd5, 1'b0);
    chk("alu_wbv",   {63'd0, wb_valid}, 64'd1);
    chk("alu_res",   wb_res, 64'h1234);
    chk("alu_dst",   {59'd0, wb_dst_reg}, 64'd5);
    chk("alu_ecall", {63'd0, wb_ecall}, 64'd0);
    chk("alu_mis",   {63'd0, wb_misaligned}, 64'd0);
    chk("alu_ready_out", {63'd0, ready}, 64'd0);
    chk("alu_noreq", {63'd0, mem.req_valid}, 64'd0);
    wb_ready = 1'b1;
    tick();
    chk("alu_done_wbv",   {63'd0, wb_valid}, 64'd0);
    chk("alu_done_ready", {63'd0, ready}, 64'd1);

    // Signed load byte at 0x1003
    issue(32'd1, 64'h1003, 64'd0, 3'b000, 5'd7, 1'b0);
    chk("lb_reqv", {63'd0, mem.req_valid}, 64'd1);
    chk("lb_addr", mem.req_addr, 64'h1000);
    chk("lb_we",   {63'd0, mem.req_we}, 64'd0);
    chk("lb_strb", {56'd0, mem.req_strb}, 64'd0);
    tick();
    chk("lb_wait_reqv", {63'd0, mem.req_valid}, 64'd0);
    chk("lb_wait_wbv",  {63'd0, wb_valid}, 64'd0);
    mem.resp_valid = 1'b1; mem.resp_data = 64'h00000000_80000000;
    tick();
    mem.resp_valid = 1'b0;
    chk("lb_wbv", {63'd0, wb_valid}, 64'd1);
    chk("lb_res", wb_res, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_dst", {59'd0, wb_dst_reg}, 64'd7);
    tick();

    // Zero-extended load byte, same access
    issue(32'd1, 64'h1003, 64'd0, 3'b100, 5'd7, 1'b0);
    tick();
    mem.resp_valid = 1'b1; mem.resp_data = 64'h00000000_80000000;
    tick();
    mem.resp_valid = 1'b0;
    chk("lbu_res", wb_res, 64'h80);
    tick();

    // Signed load half at 0x5004
    issue(32'd1, 64'h5004, 64'd0, 3'b001, 5'd8, 1'b0);
    chk("lh_addr", mem.req_addr, 64'h5000);
    tick();
    mem.resp_valid = 1'b1; mem.resp_data = 64'h0000_8001_0000_0000;
    tick();
    mem.resp_valid = 1'b0;
    chk("lh_res", wb_res, 64'hFFFF_FFFF_FFFF_8001);
    chk("lh_dst", {59'd0, wb_dst_reg}, 64'd8);
    tick();

    // Store half at 0x2006 carrying an ecall marker
    issue(32'd2, 64'h2006, 64'hABCD, 3'b001, 5'd9, 1'b1);
    chk("sh_reqv",  {63'd0, mem.req_valid}, 64'd1);
    chk("sh_addr",  mem.req_addr, 64'h2000);
    chk("sh_we",    {63'd0, mem.req_we}, 64'd1);
    chk("sh_strb",  {56'd0, mem.req_strb}, 64'hC0);
    chk("sh_wdata", mem.req_wdata, 64'hABCD_0000_0000_0000);
    tick();
    chk("sh_wbv",   {63'd0, wb_valid}, 64'd1);
    chk("sh_dst",   {59'd0, wb_dst_reg}, 64'd0);
    chk("sh_ecall", {63'd0, wb_ecall}, 64'd1);
    tick();

    // Store word at 0x6004: upper data bits shift out
    issue(32'd2, 64'h6004, 64'h1_DEAD_BEEF, 3'b010, 5'd10, 1'b0);
    chk("sw_strb",  {56'd0, mem.req_strb}, 64'hF0);
    chk("sw_wdata", mem.req_wdata, 64'hDEAD_BEEF_0000_0000);
    tick();
    tick();

    // Misaligned load word at 0x3002
    issue(32'd1, 64'h3002, 64'd0, 3'b010, 5'd4, 1'b0);
    chk("mis_noreq", {63'd0, mem.req_valid}, 64'd0);
    chk("mis_wbv",   {63'd0, wb_valid}, 64'd1);
    chk("mis_flag",  {63'd0, wb_misaligned}, 64'd1);
    chk("mis_dst",   {59'd0, wb_dst_reg}, 64'd0);
    tick();

    // Memory and writeback back-pressure on a doubleword load
    mem.req_ready = 1'b0; wb_ready = 1'b0;
    issue(32'd1, 64'h4000, 64'd0, 3'b011, 5'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_reqv",  {63'd0, mem.req_valid}, 64'd1);
      chk("stall_addr",  mem.req_addr, 64'h4000);
      chk("stall_we",    {63'd0, mem.req_we}, 64'd0);
      chk("stall_strb",  {56'd0, mem.req_strb}, 64'd0);
      chk("stall_wdata", mem.req_wdata, 64'd0);
      chk("stall_ready", {63'd0, ready}, 64'd0);
      if (i == 2) mem.req_ready = 1'b1;
      tick();
    end
    chk("stall_wait", {63'd0, mem.req_valid}, 64'd0);
    mem.resp_valid = 1'b1; mem.resp_data = 64'h1122_3344_5566_7788;
    tick();
    mem.resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_wbv",   {63'd0, wb_valid}, 64'd1);
      chk("hold_res",   wb_res, 64'h1122_3344_5566_7788);
      chk("hold_dst",   {59'd0, wb_dst_reg}, 64'd3);
      chk("hold_mis",   {63'd0, wb_misaligned}, 64'd0);
      chk("hold_ready", {63'd0, ready}, 64'd0);
      if (i == 2) wb_ready = 1'b1;
      tick();
    end
    chk("hold_done_ready", {63'd0, ready}, 64'd1);
    chk("hold_done_wbv",   {63'd0, wb_valid}, 64'd0);

    // Reset while waiting for load data, then a stray response
    issue(32'd1, 64'h7000, 64'd0, 3'b000, 5'd6, 1'b0);
    tick();
    chk("rw_in_wait", {63'd0, mem.req_valid}, 64'd0);
    reset = 1'b1;
    #1;
    chk("rw_ready", {63'd0, ready}, 64'd1);
    chk("rw_wbv",   {63'd0, wb_valid}, 64'd0);
    chk("rw_reqv",  {63'd0, mem.req_valid}, 64'd0);
    chk("rw_res",   wb_res, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    mem.resp_valid = 1'b1; mem.resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem.resp_valid = 1'b0;
    chk("stray_wbv",   {63'd0, wb_valid}, 64'd0);
    chk("stray_ready", {63'd0, ready}, 64'd1);
    chk("stray_res",   wb_res, 64'd0);
    tick();
    chk("stray_wbv2",  {63'd0, wb_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
